// File: rtl/regwr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : regwr_queue
//  Purpose  : In-order write-back queue in front of the register file write
//             port, with pending-write detection and youngest-value forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module regwr_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                       Clk,
    input  logic                       ResetL,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [4:0]                 InRW,
    input  logic [DATA_W-1:0]          InData,
    output logic [4:0]                 RW,
    output logic [DATA_W-1:0]          BusW,
    output logic                       RegWr,
    input  logic [4:0]                 QRA,
    input  logic [4:0]                 QRB,
    output logic                       PendA,
    output logic                       PendB,
    output logic [DATA_W-1:0]          FwdA,
    output logic [DATA_W-1:0]          FwdB,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int         c_PTR_W = $clog2(DEPTH);
    localparam int         c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [4:0] c_XZR   = 5'd31;

    logic [4:0]         r_rw   [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_doEnq;
    logic w_doDeq;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign InReady = !w_full;
    // Writes to XZR handshake normally but never occupy a slot.
    assign w_doEnq = InValid && InReady && (InRW != c_XZR);
    // The register file never stalls, so a non-empty head always retires.
    assign w_doDeq = !w_empty;
    assign Count   = r_count;

    assign RegWr = !w_empty;
    assign RW    = w_empty ? c_XZR : r_rw[r_head];
    assign BusW  = w_empty ? '0    : r_data[r_head];

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_doEnq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            if (w_doDeq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_doEnq) - c_CNT_W'(w_doDeq);
        end
    end

    // Payload needs no reset: it is only observed through valid/count gating.
    always_ff @(posedge Clk) begin
        if (w_doEnq) begin
            r_rw[r_tail]   <= InRW;
            r_data[r_tail] <= InData;
        end
    end

    // Walk from head toward tail so the last hit is the youngest entry.
    function automatic logic [DATA_W:0] lookup(input logic [4:0] q);
        logic [c_PTR_W-1:0] idx;
        logic [DATA_W:0]    res;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + c_PTR_W'(i);
            if ((q != c_XZR) && r_valid[idx] && (r_rw[idx] == q)) begin
                res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {PendA, FwdA} = lookup(QRA);
        {PendB, FwdB} = lookup(QRB);
    end

endmodule
`default_nettype wire
